mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter: WIDTH, 32, address and data width.
REQ-002 SHALL provide port: clk  input  1  single clock, all state on posedge.
REQ-003 SHALL provide port: rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL provide port: ifu_req_valid  input  1  IFU fetch request.
REQ-005 SHALL provide port: ifu_req_ready  output  1  IFU request accepted this cycle when high with valid.
REQ-006 SHALL provide port: ifu_addr  input  WIDTH  IFU fetch address.
REQ-007 SHALL provide port: ifu_resp_valid  output  1  response for IFU on resp_rdata.
REQ-008 SHALL provide port: ifu_resp_ready  input  1  IFU consumes response.
REQ-009 SHALL provide port: lsu_req_valid  input  1  LSU load/store request.
REQ-010 SHALL provide port: lsu_req_ready  output  1  LSU request accepted this cycle when high with valid.
REQ-011 SHALL provide port: lsu_addr  input  WIDTH  LSU address.
REQ-012 SHALL provide port: lsu_wen  input  1  1 = store, 0 = load.
REQ-013 SHALL provide port: lsu_wdata  input  WIDTH  store data.
REQ-014 SHALL provide port: lsu_wmask  input  4  store byte strobes.
REQ-015 SHALL provide port: lsu_resp_valid  output  1  response for LSU on resp_rdata.
REQ-016 SHALL provide port: lsu_resp_ready  input  1  LSU consumes response.
REQ-017 SHALL provide port: resp_rdata  output  WIDTH  mem_rdata forwarded to both masters.
REQ-018 SHALL provide port: mem_req_valid  output  1  request to memory.
REQ-019 SHALL provide port: mem_req_ready  input  1  memory accepts request.
REQ-020 SHALL provide port: mem_addr  output  WIDTH  latched address.
REQ-021 SHALL provide port: mem_wen  output  1  latched write enable.
REQ-022 SHALL provide port: mem_wdata  output  WIDTH  latched store data.
REQ-023 SHALL provide port: mem_wmask  output  4  latched strobes.
REQ-024 SHALL provide port: mem_resp_valid  input  1  memory response valid.
REQ-025 SHALL provide port: mem_rdata  input  WIDTH  memory read data.
REQ-026 SHALL provide port: mem_resp_ready  output  1  equals resp_ready of current owner in S_RESP, else 0.

Function
REQ-027 SHALL implement FSM S_IDLE, S_REQ, S_RESP; exactly one transaction outstanding.
REQ-028 S_IDLE: SHALL raise req_ready only to granted master (combinational); on valid&ready latch addr/wen/wdata/wmask/owner, go S_REQ.
REQ-029 IFU grants SHALL latch wen=0, wmask=0, wdata=0; request not accepted leaves regs unchanged.
REQ-030 S_REQ: mem_req_valid=1 with latched fields stable; on mem_req_ready go S_RESP; both req_ready=0.
REQ-031 S_RESP: owner resp_valid=mem_resp_valid, other resp_valid=0; on mem_resp_valid&mem_resp_ready go S_IDLE.
REQ-032 Latency SHALL be: accept at cycle t, mem_req_valid at t+1; next acceptance no earlier than cycle after response handshake.
REQ-033 Single requester in S_IDLE SHALL be granted regardless of priority; no requests keeps S_IDLE.
REQ-034 Simultaneous IFU and LSU requests SHALL be resolved per Configuration; loser sees req_ready=0 and retries.
REQ-035 Stores SHALL still complete the response handshake (rdata ignored by LSU).

Reset
REQ-036 rst=0 SHALL asynchronously force S_IDLE, owner=IFU, last_grant=LSU, mem_addr/mem_wen/mem_wdata/mem_wmask=0; all valid/ready outputs 0 while rst=0.
REQ-037 Reset mid-transaction SHALL drop the in-flight request/response; no stale resp_valid after release.

Configuration
REQ-038 ARB_RR_EN defined: round-robin, conflict grants master not in last_grant, last_grant updated on every acceptance; undefined: LSU fixed priority, last_grant unused.

Verification
REQ-039 IFU alone addr 0x80000000, mem_req_ready=1, mem_resp_valid 2 cycles later rdata 0x00000413 -> mem_addr 0x80000000 at t+1, ifu_resp_valid with resp_rdata 0x00000413.
REQ-040 Both request same cycle, macro off -> LSU granted; IFU granted after LSU response; repeated 3 times, IFU always second.
REQ-041 Both request continuously, ARB_RR_EN on -> grant order IFU, LSU, IFU, LSU.
REQ-042 LSU store addr 0x10, wdata 0xDEADBEEF, wmask 0xF, mem_req_ready low 3 cycles -> mem fields held stable, single acceptance.
REQ-043 ifu_resp_ready low 2 cycles during mem_resp_valid -> mem_resp_ready=0, state stays S_RESP; rst=0 in S_RESP -> immediate S_IDLE, all valids 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IFU/LSU to single-port memory arbiter, one transaction outstanding.
// Optional ARB_RR_EN: round-robin conflict resolution (default: LSU fixed priority).
module mem_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ifu_req_valid,
    output logic             ifu_req_ready,
    input  logic [WIDTH-1:0] ifu_addr,
    output logic             ifu_resp_valid,
    input  logic             ifu_resp_ready,
    input  logic             lsu_req_valid,
    output logic             lsu_req_ready,
    input  logic [WIDTH-1:0] lsu_addr,
    input  logic             lsu_wen,
    input  logic [WIDTH-1:0] lsu_wdata,
    input  logic [3:0]       lsu_wmask,
    output logic             lsu_resp_valid,
    input  logic             lsu_resp_ready,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_wen,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wmask,
    input  logic             mem_resp_valid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_resp_ready
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t state;
    logic   owner;          // 0 = IFU, 1 = LSU
    logic   lsu_prio;
    logic   lsu_win;
    logic   ifu_win;
    logic   idle;

`ifdef ARB_RR_EN
    logic   last_grant;     // 0 = IFU, 1 = LSU
    assign lsu_prio = (last_grant == 1'b0);
`else
    assign lsu_prio = 1'b1;
`endif

    // Ready is gated by rst so nothing is granted while reset is held.
    assign idle    = rst && (state == S_IDLE);
    assign lsu_win = idle && lsu_req_valid && (!ifu_req_valid || lsu_prio);
    assign ifu_win = idle && ifu_req_valid && !lsu_win;

    assign ifu_req_ready  = ifu_win;
    assign lsu_req_ready  = lsu_win;
    assign mem_req_valid  = (state == S_REQ);
    assign ifu_resp_valid = (state == S_RESP) && !owner && mem_resp_valid;
    assign lsu_resp_valid = (state == S_RESP) &&  owner && mem_resp_valid;
    assign mem_resp_ready = (state == S_RESP) && (owner ? lsu_resp_ready : ifu_resp_ready);
    assign resp_rdata     = mem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            mem_addr   <= '0;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_wmask  <= 4'h0;
`ifdef ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (lsu_win) begin
                        state      <= S_REQ;
                        owner      <= 1'b1;
                        mem_addr   <= lsu_addr;
                        mem_wen    <= lsu_wen;
                        mem_wdata  <= lsu_wdata;
                        mem_wmask  <= lsu_wmask;
`ifdef ARB_RR_EN
                        last_grant <= 1'b1;
`endif
                    end else if (ifu_win) begin
                        state      <= S_REQ;
                        owner      <= 1'b0;
                        mem_addr   <= ifu_addr;
                        mem_wen    <= 1'b0;
                        mem_wdata  <= '0;
                        mem_wmask  <= 4'h0;
`ifdef ARB_RR_EN
                        last_grant <= 1'b0;
`endif
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) state <= S_RESP;
                end
                S_RESP: begin
                    if (mem_resp_valid && mem_resp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
